// File: rtl/fetch_queue_if.sv
// fetch_queue_if: cache-side and decode-side signals of the fetch queue.
interface fetch_queue_if #(parameter int PTR_W = 2);
    logic [63:0]    ic_pc;
    logic [31:0]    ic_instruction;
    logic           redirect_valid;
    logic [63:0]    redirect_pc;
    logic           de_valid;
    logic           de_ready;
    logic [63:0]    de_pc;
    logic [31:0]    de_instruction;
    logic [PTR_W:0] count;
    logic           halted;
    modport master (
        output ic_pc, de_valid, de_pc, de_instruction, count, halted,
        input  ic_instruction, redirect_valid, redirect_pc, de_ready
    );
    modport slave (
        input  ic_pc, de_valid, de_pc, de_instruction, count, halted,
        output ic_instruction, redirect_valid, redirect_pc, de_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: owns the fetch PC and buffers {pc, instruction} pairs for decode.
// Define FETCH_HALT_DETECT_EN to stop fetching on an all-zero instruction word.
module fetch_queue #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          DEPTH    = 4,
    parameter int          PTR_W    = 2
) (
    input logic             CLK,
    input logic             RESET,
    fetch_queue_if.master   bus
);
    logic [63:0]    pc_q [DEPTH];
    logic [31:0]    instr_q [DEPTH];
    logic [63:0]    fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] count_q, count_d;
    logic           halted_q, halted_d;
    logic           full, pop, push_ok, halt_word, push;

    assign bus.ic_pc          = fetch_pc_q;
    assign bus.count          = count_q;
    assign bus.halted         = halted_q;
    assign bus.de_valid       = count_q != '0;
    assign bus.de_pc          = pc_q[rd_ptr_q];
    assign bus.de_instruction = instr_q[rd_ptr_q];

    always_comb begin
        full      = count_q == (PTR_W+1)'(DEPTH);
        pop       = bus.de_valid & bus.de_ready;
        // push never depends on pop, keeping the cache path off de_ready
        push_ok   = !full & !halted_q & !bus.redirect_valid;
`ifdef FETCH_HALT_DETECT_EN
        halt_word = bus.ic_instruction == 32'h0;
`else
        halt_word = 1'b0;
`endif
        push       = push_ok & !halt_word;
        fetch_pc_d = bus.redirect_valid ? {bus.redirect_pc[63:2], 2'b00} :
                     push ? fetch_pc_q + 64'd4 : fetch_pc_q;
        rd_ptr_d   = bus.redirect_valid ? '0 : rd_ptr_q + PTR_W'(pop);
        wr_ptr_d   = bus.redirect_valid ? '0 : wr_ptr_q + PTR_W'(push);
        count_d    = bus.redirect_valid ? '0 :
                     count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        halted_d   = bus.redirect_valid ? 1'b0 : halted_q | (push_ok & halt_word);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            halted_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            halted_q   <= halted_d;
            if (push) begin
                pc_q[wr_ptr_q]    <= fetch_pc_q;
                instr_q[wr_ptr_q] <= bus.ic_instruction;
            end
        end
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Fetch stage directly upstream of the instruction cache. Owns the fetch PC and drives it to the cache's PC input.
- Captures the 32-bit instruction returned in the same cycle and buffers {pc, instruction} pairs in a small FIFO.
- Decode consumes the FIFO through a valid/ready handshake.
- Branch/jump redirects flush the queue and reload the PC.

Parameters:
- RESET_PC, 64'h0, fetch PC loaded on reset.
- DEPTH, 4, queue entries; must be a power of 2, minimum 2.
- PTR_W, 2, log2(DEPTH); must match DEPTH.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- ic_pc  output  64  fetch address to the instruction cache; equals the fetch_pc register.
- ic_instruction  input  32  instruction word from the cache for ic_pc; combinational, same cycle.
- redirect_valid  input  1  branch/jump redirect request from execute.
- redirect_pc  input  64  redirect target; bits [1:0] are ignored and treated as 0.
- de_valid  output  1  queue head is valid.
- de_ready  input  1  decode accepts the head this cycle.
- de_pc  output  64  PC of the queue head.
- de_instruction  output  32  instruction at the queue head.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.
- halted  output  1  fetch is stopped on a halt word (see Optional Feature).

Behaviour:
- Reset (RESET=1 at a clock edge):
  - fetch_pc=RESET_PC, rd_ptr=wr_ptr=0, count=0, halted=0.
  - All storage entries cleared to 0.
  - Resulting outputs: de_valid=0, de_pc=0, de_instruction=0, ic_pc=RESET_PC.
  - RESET has priority over every other input; asserting it mid-stream discards all queued entries.
- Outputs:
  - de_valid = (count != 0).
  - de_pc and de_instruction are read combinationally from storage[rd_ptr].
  - ic_pc = fetch_pc.
- Signals:
  - full = (count == DEPTH), based on the registered count.
  - pop = de_valid & de_ready.
  - push = !full & !halted & !redirect_valid.
- Priority per cycle:
  1. RESET.
  2. redirect_valid: count=0, rd_ptr=wr_ptr=0, fetch_pc={redirect_pc[63:2],2'b00}, halted=0. No push. A pop in the same cycle is discarded; the entry is flushed regardless.
  3. Normal operation:
     - If push: storage[wr_ptr]={fetch_pc, ic_instruction}, wr_ptr+1, fetch_pc+4.
     - If pop: rd_ptr+1.
     - count updates by +push-pop; push and pop together leave count unchanged.
- Full handling: push is blocked whenever full, even if a pop occurs in the same cycle. This is a deliberate no-bypass rule that keeps the cache path off the decode ready path. fetch_pc holds while full.
- Empty handling: a pop is impossible when empty because de_valid=0; de_ready is ignored.
- Wrap-around:
  - Pointers wrap modulo DEPTH.
  - fetch_pc+4 wraps modulo 2^64.
- Latency:
  - An instruction fetched at cycle N is visible on de_* at cycle N+1 at the earliest.
  - The first valid instruction after a redirect appears 2 cycles after redirect_valid: one cycle to load the PC, one cycle to push.
- Steady state: with de_ready held at 1, the block sustains 1 instruction per cycle.

Optional Feature:
- Macro: FETCH_HALT_DETECT_EN.
- Defined:
  - A push candidate whose ic_instruction == 32'h0000_0000 (the zero-filled-memory halt word) is not written to the queue. Instead, halted <= 1 and fetch_pc holds.
  - While halted, no pushes occur; the queue drains normally to decode.
  - halted clears only on redirect_valid or RESET.
- Not defined:
  - A zero word is queued like any other instruction.
  - halted is tied to 0.

Test Plan:
- Stream: RESET, then de_ready=1, cache returns ic_instruction=ic_pc[31:0]^32'hA5A5_0000 -> de_valid rises at cycle 1; de_pc sequence 0,4,8,...; one entry per cycle; count stays 1.
- Backpressure: de_ready=0 for 10 cycles -> count saturates at 4, ic_pc holds at 0x10. Then de_ready=1 -> entries popped in order with de_pc 0,4,8,C, then 0x10 follows with no gap or duplicate.
- Full with simultaneous pop: count=4, de_ready=1 for one cycle -> count=3, no push that cycle, ic_pc unchanged. Next cycle push resumes.
- Redirect: queue holding 3 entries, redirect_valid=1 with redirect_pc=0x203, de_ready=1 -> next cycle count=0, de_valid=0, ic_pc=0x200. The cycle after, de_pc=0x200. Stale entries never appear.
- Reset mid-operation: count=3, RESET=1 for one cycle -> de_valid=0, count=0, ic_pc=RESET_PC. Fetch restarts from RESET_PC.
- Halt (FETCH_HALT_DETECT_EN defined): words at 0x0 and 0x4 nonzero, word at 0x8 is zero -> 2 entries delivered; halted=1; ic_pc stays at 0x8; de_valid=0 after drain. redirect_pc=0x0 -> halted=0 and fetch resumes. Without the macro: the 0x8 zero word is delivered and halted stays 0.
